// File: rtl/cache_sram_pkg.sv
// Shared types for the cache SRAM block: controller state encoding.
package cache_sram_pkg;

    // Controller states: zeroing sweep, then normal request service.
    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/cache_sram_bytemerge.sv
// Combinational byte-lane merge: each lane takes din where its mask bit is set,
// otherwise keeps the old word's lane.
module cache_sram_bytemerge #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_old_word,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [NUM_WMASKS-1:0] i_mask,
    output logic [DATA_WIDTH-1:0] o_new_word
);

    // Per-lane select between old and incoming data.
    always_comb begin
        o_new_word = i_old_word;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (i_mask[i]) begin
                o_new_word[i*BYTE_WIDTH +: BYTE_WIDTH] = i_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/cache_sram_1rw.sv
// Single-port cache SRAM with byte-masked writes, write-through read data and a
// self-zeroing initialisation sweep after reset or on clr0.
module cache_sram_1rw
    import cache_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr0,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    output logic                             ready0,
    output logic [DATA_WIDTH-1:0]            dout0,
    output logic                             dout_valid0
);

    localparam int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    // Storage has no reset; contents become defined through the zeroing sweep.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // clr0 wins over a simultaneous request.
    assign w_accept   = (r_state == StRun) && !csb0 && !clr0;
    assign w_old_word = r_mem[addr0];

    cache_sram_bytemerge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_bytemerge (
        .i_old_word (w_old_word),
        .i_din      (din0),
        .i_mask     (wmask0),
        .o_new_word (w_merged)
    );

    // Single write port: the sweep owns it in INIT, accepted writes in RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = addr0;
        w_mem_wdata = w_merged;
        if (!rst) begin
            if (r_state == StInit) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cnt;
                w_mem_wdata = '0;
            end else if (w_accept && !web0) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Memory array write; a zero mask rewrites the unchanged word.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Controller FSM with registered read data and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StInit;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StInit: begin
                    r_dout_valid <= 1'b0;
                    if (clr0) begin
                        r_cnt <= '0;
                    end else if (r_cnt == '1) begin
                        // Last word zeroed; counter holds rather than wrapping.
                        r_state <= StRun;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                StRun: begin
                    if (clr0) begin
                        r_state      <= StInit;
                        r_cnt        <= '0;
                        r_dout_valid <= 1'b0;
                    end else if (!csb0) begin
                        r_dout_valid <= 1'b1;
                        r_dout       <= web0 ? w_old_word : w_merged;
                    end else begin
                        r_dout_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StInit;
                    r_cnt        <= '0;
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready0      = (r_state == StRun);
    assign dout0       = r_dout;
    assign dout_valid0 = r_dout_valid;

endmodule
